// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared sizes, FSM state encoding and colour constants for the
//            frame-buffer arbiter slice.
// Revision : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_ADDR_W = 10;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 1024;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/fb_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fb_clear_sequencer
// Purpose  : Full-buffer fill sequencer: address counter, colour latch, stall
//            and terminal detect. Optional macro FB_AUTOCLEAR_EN starts a
//            black fill automatically when reset is released.
// Revision : 1.0  initial release
// ============================================================================
module fb_clear_sequencer
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_color,
    input  logic              i_stall,
    output logic              o_starting,
    output logic              o_active,
    output logic              o_busy,
    output logic              o_wr_grant,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_color
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_color;
    logic              r_busy;
    logic              r_last_issued;
    logic              w_start_req;
    logic [DATA_W-1:0] w_start_color;
    logic              w_terminal;

`ifdef FB_AUTOCLEAR_EN
    // Pending pseudo-start held through reset, consumed on the first clock.
    logic r_auto_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_pend <= 1'b1;
        end else begin
            r_auto_pend <= 1'b0;
        end
    end

    assign w_start_req   = i_start | r_auto_pend;
    assign w_start_color = r_auto_pend ? DATA_W'(COLOR_BLACK) : i_color;
`else
    assign w_start_req   = i_start;
    assign w_start_color = i_color;
`endif

    assign o_starting = w_start_req && (r_state == ST_IDLE);
    assign o_active   = (r_state == ST_CLEAR);
    assign o_wr_grant = o_active && !i_stall;
    assign w_terminal = o_wr_grant && (r_count == c_last_addr);
    assign o_busy     = r_busy;
    assign o_addr     = r_count;
    assign o_color    = r_color;

    // Busy drops one cycle after the final write reaches the RAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_color       <= '0;
            r_busy        <= 1'b0;
            r_last_issued <= 1'b0;
        end else begin
            r_last_issued <= w_terminal;
            if (o_starting) begin
                r_state <= ST_CLEAR;
                r_count <= '0;
                r_color <= w_start_color;
                r_busy  <= 1'b1;
            end else begin
                if (w_terminal) begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end else if (o_wr_grant) begin
                    r_count <= r_count + 1'b1;
                end
                if (r_last_issued) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_arbiter
// Purpose  : Single-port frame RAM arbiter: VGA fetch > clear fill > draw
//            write, registered RAM port and 3-cycle VGA read pipeline.
//            Optional macro FB_AUTOCLEAR_EN (see fb_clear_sequencer).
// Revision : 1.0  initial release
// ============================================================================
module framebuffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              w_clr_starting;
    logic              w_clr_active;
    logic              w_clr_grant;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_color;
    logic              w_draw_grant;

    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_draw_ack;
    logic              r_rd_p1;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_data;

    fb_clear_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .i_start    (clr_start),
        .i_color    (clr_color),
        .i_stall    (vga_req),
        .o_starting (w_clr_starting),
        .o_active   (w_clr_active),
        .o_busy     (clr_busy),
        .o_wr_grant (w_clr_grant),
        .o_addr     (w_clr_addr),
        .o_color    (w_clr_color)
    );

    // A request still high in its own ack cycle must not be granted again.
    assign w_draw_grant = draw_req && !vga_req && !r_draw_ack
                       && !w_clr_active && !w_clr_starting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_draw_ack  <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_vga_valid <= 1'b0;
            r_vga_data  <= '0;
        end else begin
            r_ram_en   <= vga_req || w_clr_grant || w_draw_grant;
            r_ram_we   <= w_clr_grant || w_draw_grant;
            r_draw_ack <= w_draw_grant;
            if (vga_req) begin
                r_ram_addr  <= vga_addr;
                r_ram_wdata <= '0;
            end else if (w_clr_grant) begin
                r_ram_addr  <= w_clr_addr;
                r_ram_wdata <= w_clr_color;
            end else if (w_draw_grant) begin
                r_ram_addr  <= draw_addr;
                r_ram_wdata <= draw_data;
            end else begin
                r_ram_addr  <= '0;
                r_ram_wdata <= '0;
            end
            r_rd_p1     <= r_ram_en && !r_ram_we;
            r_vga_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_vga_data <= ram_rdata;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign draw_ack  = r_draw_ack;
    assign vga_valid = r_vga_valid;
    assign vga_data  = r_vga_data;

endmodule
`default_nettype wire
